exec_sequencer: RTL and testbench



---
 rtl/exec_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control sequencer for the XMakina core.
// Walks each instruction through fetch, decode, operand, execute, memory
// and writeback states and drives the matching datapath enables.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall               hold request, honoured only in FETCH
//   fetch_done          instruction word ready (sampled in FETCH_WAIT)
//   mem_done            memory access complete (sampled in MEM)
//   branch_taken        branch condition from decode/PSW
//   macro_op[2:0]       instruction class from decoder
//   reg_wb[1:0]         register writeback byte enables from decoder
//   exec_state[3:0]     current state code when DEBUG=1, else 0
//   fetch_en .. reg_wr_en  per-state datapath enables (registered)
//   instr_retired       pulse during the final cycle of each instruction
//   retire_count        retired-instruction counter, wraps
module exec_sequencer #(
   parameter int unsigned DEBUG    = 0,
   parameter int unsigned MEM_WAIT = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             fetch_done,
   input  logic             mem_done,
   input  logic             branch_taken,
   input  logic [2:0]       macro_op,
   input  logic [1:0]       reg_wb,
   output logic [3:0]       exec_state,
   output logic             fetch_en,
   output logic             pc_fetch_wr,
   output logic             decode_en,
   output logic             alu_in_en,
   output logic             alu_out_en,
   output logic             branch_en,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [1:0]       reg_wr_en,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retire_count
);

   localparam int unsigned WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT - 1);

   localparam logic [2:0] OP_BL        = 3'd0;
   localparam logic [2:0] OP_CBRANCH   = 3'd1;
   localparam logic [2:0] OP_LOAD      = 3'd3;
   localparam logic [2:0] OP_STORE     = 3'd4;
   localparam logic [2:0] OP_SYSCALL   = 3'd5;
   localparam logic [2:0] OP_COND_EXEC = 3'd6;

   typedef enum logic [3:0] {
      S_INIT       = 4'd0,
      S_FETCH      = 4'd1,
      S_FETCH_WAIT = 4'd2,
      S_INC_PC     = 4'd3,
      S_DECODE     = 4'd4,
      S_OPERAND    = 4'd5,
      S_ALU_EXEC   = 4'd6,
      S_BRANCH     = 4'd7,
      S_NOP        = 4'd8,
      S_MEM        = 4'd9,
      S_WRITE_BACK = 4'd10
   } state_t;

   state_t            state, next_state;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              retire;

   logic       fetch_en_nxt, pc_fetch_wr_nxt, decode_en_nxt, alu_in_en_nxt;
   logic       alu_out_en_nxt, branch_en_nxt, mem_en_nxt, mem_wr_nxt;
   logic [1:0] reg_wr_en_nxt;

   // Next state, memory wait counter, retire, and next-cycle enable decode.
   // Enables are decoded from next_state so they appear registered yet line
   // up with the state they belong to; the decoder inputs they use are stable
   // from OPERAND until retire.
   always_comb begin
      next_state      = S_INIT;
      wait_nxt        = wait_cnt;
      retire          = 1'b0;
      fetch_en_nxt    = 1'b0;
      pc_fetch_wr_nxt = 1'b0;
      decode_en_nxt   = 1'b0;
      alu_in_en_nxt   = 1'b0;
      alu_out_en_nxt  = 1'b0;
      branch_en_nxt   = 1'b0;
      mem_en_nxt      = 1'b0;
      mem_wr_nxt      = 1'b0;
      reg_wr_en_nxt   = 2'b00;

      case (state)
         S_INIT:       next_state = S_FETCH;
         S_FETCH:      next_state = stall ? S_FETCH : S_FETCH_WAIT;
         S_FETCH_WAIT: next_state = fetch_done ? S_INC_PC : S_FETCH_WAIT;
         S_INC_PC:     next_state = S_DECODE;
         S_DECODE:     next_state = S_OPERAND;
         S_OPERAND: begin
            if (macro_op == OP_BL || macro_op == OP_CBRANCH)
               next_state = S_BRANCH;
            else if (macro_op == OP_SYSCALL || macro_op == OP_COND_EXEC)
               next_state = S_NOP;
            else
               next_state = S_ALU_EXEC;
         end
         S_BRANCH: begin
            // Only a taken BL needs the link register write.
            if (macro_op == OP_BL && branch_taken) begin
               next_state = S_WRITE_BACK;
            end else begin
               next_state = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_ALU_EXEC: begin
            if (macro_op == OP_LOAD || macro_op == OP_STORE) begin
               next_state = S_MEM;
               wait_nxt   = '0;
            end else begin
               next_state = S_WRITE_BACK;
            end
         end
         S_MEM: begin
            next_state = S_MEM;
            if (wait_cnt != WAIT_MAX)
               wait_nxt = wait_cnt + 1'b1;
            // An early mem_done is ignored until the minimum latency elapses.
            if (mem_done && wait_cnt == WAIT_MAX) begin
               if (macro_op == OP_STORE) begin
                  next_state = S_FETCH;
                  retire     = 1'b1;
               end else begin
                  next_state = S_WRITE_BACK;
               end
            end
         end
         S_NOP: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         S_WRITE_BACK: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         default:      next_state = S_INIT;
      endcase

      case (next_state)
         S_FETCH, S_FETCH_WAIT: fetch_en_nxt    = 1'b1;
         S_INC_PC:              pc_fetch_wr_nxt = 1'b1;
         S_DECODE:              decode_en_nxt   = 1'b1;
         S_OPERAND:             alu_in_en_nxt   = 1'b1;
         S_ALU_EXEC:            alu_out_en_nxt  = 1'b1;
         S_BRANCH: begin
            branch_en_nxt   = 1'b1;
            pc_fetch_wr_nxt = branch_taken;
         end
         S_MEM: begin
            mem_en_nxt = 1'b1;
            mem_wr_nxt = (macro_op == OP_STORE);
         end
         S_WRITE_BACK:          reg_wr_en_nxt   = reg_wb;
         default: ;
      endcase
   end

   // State, wait counter, retire counter and registered enables.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_INIT;
         wait_cnt     <= '0;
         retire_count <= '0;
         fetch_en     <= 1'b0;
         pc_fetch_wr  <= 1'b0;
         decode_en    <= 1'b0;
         alu_in_en    <= 1'b0;
         alu_out_en   <= 1'b0;
         branch_en    <= 1'b0;
         mem_en       <= 1'b0;
         mem_wr       <= 1'b0;
         reg_wr_en    <= 2'b00;
      end else begin
         state       <= next_state;
         wait_cnt    <= wait_nxt;
         if (retire)
            retire_count <= retire_count + 1'b1;
         fetch_en    <= fetch_en_nxt;
         pc_fetch_wr <= pc_fetch_wr_nxt;
         decode_en   <= decode_en_nxt;
         alu_in_en   <= alu_in_en_nxt;
         alu_out_en  <= alu_out_en_nxt;
         branch_en   <= branch_en_nxt;
         mem_en      <= mem_en_nxt;
         mem_wr      <= mem_wr_nxt;
         reg_wr_en   <= reg_wr_en_nxt;
      end
   end

   // The store exit depends on mem_done in the same cycle, so the retire
   // pulse is a direct decode; a reset in that cycle aborts the retire.
   assign instr_retired = retire & ~reset;
   assign exec_state    = (DEBUG != 0) ? state : 4'd0;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer (MEM_WAIT=2, CNT_W=4).
// The driver issues one instruction at a time and pushes a hand-computed
// per-instruction signature; the monitor accumulates the DUT's outputs and
// compares on every instr_retired pulse. A DEBUG=0 twin shares the inputs.
module tb_exec_sequencer;

   typedef struct {
      int cyc;
      int mask;
      int pcwr;
      int mem;
      int memwr;
      int wbsum;
      int fetch;
      int cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, stall, fetch_done, mem_done, branch_taken;
   logic [2:0] macro_op;
   logic [1:0] reg_wb;

   logic [3:0] exec_state_d, exec_state_n;
   logic       fetch_en_d, pc_fetch_wr_d, decode_en_d, alu_in_en_d, alu_out_en_d;
   logic       branch_en_d, mem_en_d, mem_wr_d, instr_retired_d;
   logic [1:0] reg_wr_en_d;
   logic [3:0] retire_count_d;
   logic       fetch_en_n, pc_fetch_wr_n, decode_en_n, alu_in_en_n, alu_out_en_n;
   logic       branch_en_n, mem_en_n, mem_wr_n, instr_retired_n;
   logic [1:0] reg_wr_en_n;
   logic [3:0] retire_count_n;

   int   total = 0;
   int   bad   = 0;
   int   nz_state = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   exec_sequencer #(.DEBUG(1), .MEM_WAIT(2), .CNT_W(4)) u_dbg (
      .clk(clk), .reset(reset), .stall(stall), .fetch_done(fetch_done),
      .mem_done(mem_done), .branch_taken(branch_taken), .macro_op(macro_op),
      .reg_wb(reg_wb), .exec_state(exec_state_d), .fetch_en(fetch_en_d),
      .pc_fetch_wr(pc_fetch_wr_d), .decode_en(decode_en_d),
      .alu_in_en(alu_in_en_d), .alu_out_en(alu_out_en_d),
      .branch_en(branch_en_d), .mem_en(mem_en_d), .mem_wr(mem_wr_d),
      .reg_wr_en(reg_wr_en_d), .instr_retired(instr_retired_d),
      .retire_count(retire_count_d)
   );

   exec_sequencer #(.DEBUG(0), .MEM_WAIT(2), .CNT_W(4)) u_nodbg (
      .clk(clk), .reset(reset), .stall(stall), .fetch_done(fetch_done),
      .mem_done(mem_done), .branch_taken(branch_taken), .macro_op(macro_op),
      .reg_wb(reg_wb), .exec_state(exec_state_n), .fetch_en(fetch_en_n),
      .pc_fetch_wr(pc_fetch_wr_n), .decode_en(decode_en_n),
      .alu_in_en(alu_in_en_n), .alu_out_en(alu_out_en_n),
      .branch_en(branch_en_n), .mem_en(mem_en_n), .mem_wr(mem_wr_n),
      .reg_wr_en(reg_wr_en_n), .instr_retired(instr_retired_n),
      .retire_count(retire_count_n)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int cyc, input int mask, input int pcwr,
                               input int mem, input int memwr, input int wbsum,
                               input int fetch, input int cnt);
      exp_t e;
      e.cyc = cyc; e.mask = mask; e.pcwr = pcwr; e.mem = mem;
      e.memwr = memwr; e.wbsum = wbsum; e.fetch = fetch; e.cnt = cnt;
      return e;
   endfunction

   // Monitor: accumulate per-instruction signature, compare on retire.
   initial begin
      exp_t e;
      int a_cyc, a_mask, a_pcwr, a_mem, a_memwr, a_wb, a_fetch;
      a_cyc = 0; a_mask = 0; a_pcwr = 0; a_mem = 0; a_memwr = 0; a_wb = 0; a_fetch = 0;
      forever begin
         @(negedge clk); #2;
         if (exec_state_n != 4'd0) nz_state++;
         if (reset) begin
            a_cyc = 0; a_mask = 0; a_pcwr = 0; a_mem = 0; a_memwr = 0; a_wb = 0; a_fetch = 0;
         end else begin
            a_cyc++;
            a_mask  |= (1 << exec_state_d);
            a_pcwr  += int'(pc_fetch_wr_d);
            a_mem   += int'(mem_en_d);
            a_memwr += int'(mem_wr_d);
            a_wb    += int'(reg_wr_en_d);
            a_fetch += int'(fetch_en_d);
            if (instr_retired_d) begin
               if (q.size() == 0) begin
                  chk("unexpected_retire", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("cycles",       a_cyc,   e.cyc);
                  chk("state_mask",   a_mask,  e.mask);
                  chk("pc_fetch_wr",  a_pcwr,  e.pcwr);
                  chk("mem_en",       a_mem,   e.mem);
                  chk("mem_wr",       a_memwr, e.memwr);
                  chk("reg_wr_en",    a_wb,    e.wbsum);
                  chk("fetch_en",     a_fetch, e.fetch);
                  chk("retire_count", int'(retire_count_d), e.cnt);
               end
               a_cyc = 0; a_mask = 0; a_pcwr = 0; a_mem = 0; a_memwr = 0; a_wb = 0; a_fetch = 0;
            end
         end
      end
   end

   // Issue one instruction from FETCH; sl/fl/ml are stall cycles, fetch_done
   // delay and mem_done delay. With abort set, reset is raised in first MEM.
   task automatic run_instr(input int op, input int wb, input bit tk,
                            input int sl, input int fl, input int ml,
                            input bit abort, input exp_t e);
      int st;
      bit found, done;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (exec_state_d == 4'd1) begin found = 1'b1; break; end
      end
      if (!found) begin chk("wait_fetch", 0, 1); return; end
      macro_op = 3'(op); reg_wb = 2'(wb); branch_taken = tk;
      if (!abort) q.push_back(e);
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         st = int'(exec_state_d);
         if (abort && st == 9) begin reset = 1'b1; done = 1'b1; break; end
         stall = (st == 1 && sl > 0);
         if (stall) sl--;
         fetch_done = (st == 2 && fl == 0);
         if (st == 2 && fl > 0) fl--;
         mem_done = (st == 9 && ml == 0);
         if (st == 9 && ml > 0) ml--;
         #1;
         if (instr_retired_d) begin done = 1'b1; break; end
         @(negedge clk); #1;
      end
      if (!done) chk("instr_timeout", 0, 1);
   endtask

   initial begin
      exp_t none;
      none = mk(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1; stall = 1'b0; fetch_done = 1'b0; mem_done = 1'b0;
      branch_taken = 1'b0; macro_op = 3'd0; reg_wb = 2'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state", int'(exec_state_d), 0);
      chk("rst_outputs", int'({fetch_en_d, pc_fetch_wr_d, decode_en_d, alu_in_en_d,
                               alu_out_en_d, branch_en_d, mem_en_d, mem_wr_d,
                               reg_wr_en_d, instr_retired_d}), 0);
      chk("rst_count", int'(retire_count_d), 0);
      reset = 1'b0;

      //        op wb tk sl fl ml ab   cyc  mask  pcwr mem memwr wb fetch cnt
      run_instr(2, 3, 0, 0, 0, 0, 0, mk(8, 'h47F, 1, 0, 0, 3, 2, 0));   // ALU after reset
      run_instr(3, 1, 0, 0, 0, 0, 0, mk(9, 'h67E, 1, 2, 0, 1, 2, 1));   // LOAD
      run_instr(4, 2, 0, 0, 0, 3, 0, mk(10, 'h27E, 1, 4, 4, 0, 2, 2));  // STORE, late mem_done
      run_instr(0, 3, 1, 0, 0, 0, 0, mk(7, 'h4BE, 2, 0, 0, 3, 2, 3));   // BL taken
      run_instr(1, 3, 0, 0, 0, 0, 0, mk(6, 'h0BE, 1, 0, 0, 0, 2, 4));   // CBRANCH not taken
      run_instr(1, 3, 1, 0, 0, 0, 0, mk(6, 'h0BE, 2, 0, 0, 0, 2, 5));   // CBRANCH taken
      run_instr(0, 3, 0, 0, 0, 0, 0, mk(6, 'h0BE, 1, 0, 0, 0, 2, 6));   // BL not taken
      run_instr(7, 1, 0, 5, 3, 0, 0, mk(15, 'h47E, 1, 0, 0, 1, 10, 7)); // MOVI, stall + slow fetch
      run_instr(5, 3, 0, 0, 0, 0, 0, mk(6, 'h13E, 1, 0, 0, 0, 2, 8));   // SYSCALL
      run_instr(6, 3, 0, 0, 0, 0, 0, mk(6, 'h13E, 1, 0, 0, 0, 2, 9));   // COND_EXEC
      for (int i = 0; i < 16; i++)
         run_instr(5, 3, 0, 0, 0, 0, 0, mk(6, 'h13E, 1, 0, 0, 0, 2, (10 + i) % 16));

      // Reset while in MEM aborts the load with no retire.
      run_instr(3, 1, 0, 0, 0, 100, 1, none);
      @(negedge clk); #1;
      chk("abort_state", int'(exec_state_d), 0);
      chk("abort_mem_en", int'(mem_en_d), 0);
      chk("abort_outputs", int'({fetch_en_d, pc_fetch_wr_d, decode_en_d, alu_in_en_d,
                                 alu_out_en_d, branch_en_d, mem_wr_d, reg_wr_en_d,
                                 instr_retired_d}), 0);
      chk("abort_count", int'(retire_count_d), 0);
      reset = 1'b0;
      run_instr(2, 2, 0, 0, 0, 0, 0, mk(8, 'h47F, 1, 0, 0, 2, 2, 0));

      repeat (4) @(negedge clk);
      #3;
      chk("queue_empty", q.size(), 0);
      chk("nodbg_state_nonzero_cycles", nz_state, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
